// File: rtl/mem_bus_arbiter.sv
// Round-robin two-master arbiter with lock and watchdog onto one byte-wide memory port.
// Latency: strobe 1 cycle after request, mX_ack 1 cycle after mem_ack; losing master is held off, never dropped.
module mem_bus_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_rd_req,
    input  logic              m0_wr_req,
    input  logic [DATA_W-1:0] m0_wr_data,
    input  logic              m0_lock,
    output logic [DATA_W-1:0] m0_rd_data,
    output logic              m0_ack,
    output logic              m0_err,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_rd_req,
    input  logic              m1_wr_req,
    input  logic [DATA_W-1:0] m1_wr_data,
    input  logic              m1_lock,
    output logic [DATA_W-1:0] m1_rd_data,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_wr_enable,
    output logic              mem_rd_req,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_ack,
    output logic [1:0]        grant
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    localparam int                CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wr_data;
    logic               r_wr_en;
    logic               r_rd_req;
    logic [1:0]         r_grant;
    logic               r_owner;
    logic               r_last;
    logic               r_lock_vld;
    logic               r_lock_id;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_m0_rd_data;
    logic [DATA_W-1:0]  r_m1_rd_data;
    logic [1:0]         r_ack;
    logic [1:0]         r_err;

    logic               w_req0;
    logic               w_req1;
    logic               w_lock_hit;
    logic               w_sel;
    logic               w_gnt;
    logic               w_wr;
    logic               w_timeout;

    always_comb begin
        w_req0      = m0_rd_req | m0_wr_req;
        w_req1      = m1_rd_req | m1_wr_req;
        w_lock_hit  = r_lock_vld && (r_lock_id ? w_req1 : w_req0);
        w_gnt       = w_req0 | w_req1;
        w_sel       = 1'b0;
        if (w_lock_hit) begin
            w_sel = r_lock_id;
        end else if (w_req0 && w_req1) begin
            w_sel = ~r_last;
        end else begin
            w_sel = w_req1;
        end
        w_wr        = w_sel ? m1_wr_req : m0_wr_req;
        w_timeout   = (TIMEOUT != 0) && (r_cnt == CNT_LAST);
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_gnt) w_state_nxt = S_WAIT;
            S_WAIT:  if (mem_ack || w_timeout) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_addr    <= '0;
            r_mem_wr_data <= '0;
            r_wr_en       <= 1'b0;
            r_rd_req      <= 1'b0;
            r_grant       <= 2'b00;
            r_owner       <= 1'b0;
            r_last        <= 1'b1;
            r_lock_vld    <= 1'b0;
            r_lock_id     <= 1'b0;
            r_cnt         <= '0;
            r_m0_rd_data  <= '0;
            r_m1_rd_data  <= '0;
            r_ack         <= 2'b00;
            r_err         <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A stale lock whose owner went quiet must not block the other master.
                    if (r_lock_vld && !w_lock_hit) begin
                        r_lock_vld <= 1'b0;
                    end
                    if (w_gnt) begin
                        r_mem_addr    <= w_sel ? m1_addr : m0_addr;
                        r_mem_wr_data <= w_sel ? m1_wr_data : m0_wr_data;
                        r_wr_en       <= w_wr;
                        r_rd_req      <= ~w_wr;
                        r_grant       <= w_sel ? 2'b10 : 2'b01;
                        r_owner       <= w_sel;
                        r_last        <= w_sel;
                        r_cnt         <= '0;
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        r_wr_en  <= 1'b0;
                        r_rd_req <= 1'b0;
                        if (r_rd_req) begin
                            if (r_owner) r_m1_rd_data <= mem_rd_data;
                            else         r_m0_rd_data <= mem_rd_data;
                        end
                        r_ack[r_owner] <= 1'b1;
                    end else if (w_timeout) begin
                        r_wr_en  <= 1'b0;
                        r_rd_req <= 1'b0;
                        if (r_owner) r_m1_rd_data <= '1;
                        else         r_m0_rd_data <= '1;
                        r_ack[r_owner] <= 1'b1;
                        r_err[r_owner] <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_ack      <= 2'b00;
                    r_err      <= 2'b00;
                    r_grant    <= 2'b00;
                    r_lock_vld <= r_owner ? m1_lock : m0_lock;
                    r_lock_id  <= r_owner;
                end
                default: begin
                    r_ack   <= 2'b00;
                    r_err   <= 2'b00;
                    r_grant <= 2'b00;
                end
            endcase
        end
    end

    assign mem_addr      = r_mem_addr;
    assign mem_wr_data   = r_mem_wr_data;
    assign mem_wr_enable = r_wr_en;
    assign mem_rd_req    = r_rd_req;
    assign grant         = r_grant;
    assign m0_rd_data    = r_m0_rd_data;
    assign m1_rd_data    = r_m1_rd_data;
    assign m0_ack        = r_ack[0];
    assign m1_ack        = r_ack[1];
    assign m0_err        = r_err[0];
    assign m1_err        = r_err[1];

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed requests push expected completions, a monitor checks them.
// A behavioural memory acks after a programmable number of strobe cycles (0 = never).
module tb_mem_bus_arbiter;

    typedef struct packed {
        logic       m;
        logic [7:0] dat;
        logic       err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] m0_addr, m1_addr, mem_addr;
    logic        m0_rd_req, m0_wr_req, m0_lock, m0_ack, m0_err;
    logic        m1_rd_req, m1_wr_req, m1_lock, m1_ack, m1_err;
    logic [7:0]  m0_wr_data, m1_wr_data, m0_rd_data, m1_rd_data;
    logic [7:0]  mem_wr_data, mem_rd_data;
    logic        mem_wr_enable, mem_rd_req, mem_ack;
    logic [1:0]  grant;

    exp_t        exp_q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          ack_delay = 2;
    int          last_len  = 0;
    logic [15:0] cap_addr;
    logic [7:0]  cap_wdata;
    logic        cap_wr;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .TIMEOUT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_addr(m0_addr), .m0_rd_req(m0_rd_req), .m0_wr_req(m0_wr_req),
        .m0_wr_data(m0_wr_data), .m0_lock(m0_lock), .m0_rd_data(m0_rd_data),
        .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_addr(m1_addr), .m1_rd_req(m1_rd_req), .m1_wr_req(m1_wr_req),
        .m1_wr_data(m1_wr_data), .m1_lock(m1_lock), .m1_rd_data(m1_rd_data),
        .m1_ack(m1_ack), .m1_err(m1_err),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_enable(mem_wr_enable),
        .mem_rd_req(mem_rd_req), .mem_rd_data(mem_rd_data), .mem_ack(mem_ack),
        .grant(grant)
    );

    function automatic logic [7:0] mem_lookup(input logic [15:0] a);
        case (a)
            16'h0444: return 8'hA9;
            16'h0445: return 8'h45;
            16'h0446: return 8'h46;
            16'h1000: return 8'h10;
            16'h1001: return 8'h11;
            16'h2000: return 8'h20;
            16'h3000: return 8'h30;
            default:  return 8'h77;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic m, input logic [7:0] dat, input logic err);
        exp_t e;
        e.m = m; e.dat = dat; e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic req(input int m, input logic wr, input logic [15:0] a,
                       input logic [7:0] d, input logic lk);
        if (m == 0) begin
            m0_addr = a; m0_wr_data = d; m0_lock = lk; m0_wr_req = wr; m0_rd_req = ~wr;
        end else begin
            m1_addr = a; m1_wr_data = d; m1_lock = lk; m1_wr_req = wr; m1_rd_req = ~wr;
        end
    endtask

    task automatic drop(input int m);
        if (m == 0) begin m0_rd_req = 1'b0; m0_wr_req = 1'b0; m0_lock = 1'b0; end
        else        begin m1_rd_req = 1'b0; m1_wr_req = 1'b0; m1_lock = 1'b0; end
    endtask

    task automatic wait_ack(input int m, output int k);
        bit found;
        found = 1'b0;
        k = 0;
        while (!found && k < 60) begin
            @(negedge clk);
            k++;
            found = (m == 0) ? m0_ack : m1_ack;
        end
        chk($sformatf("ack_seen_m%0d", m), 32'(found), 32'd1);
    endtask

    // Memory model: acks in the ack_delay-th strobe cycle and records each transfer.
    initial begin
        int cnt;
        cnt = 0;
        mem_ack = 1'b0;
        mem_rd_data = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (mem_rd_req || mem_wr_enable) begin
                if (cnt == 0) begin
                    cap_addr = mem_addr; cap_wdata = mem_wr_data; cap_wr = mem_wr_enable;
                end else begin
                    chk("strobe_addr_hold", 32'(mem_addr), 32'(cap_addr));
                end
                cnt++;
                mem_ack     = (ack_delay != 0) && (cnt == ack_delay);
                mem_rd_data = mem_ack ? mem_lookup(mem_addr) : 8'h00;
            end else begin
                if (cnt != 0) last_len = cnt;
                cnt = 0;
                mem_ack = 1'b0;
                mem_rd_data = 8'h00;
            end
        end
    end

    initial begin
        exp_t       e;
        logic [1:0] ev;
        forever begin
            @(negedge clk);
            if (m0_ack | m1_ack | m0_err | m1_err) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 32'({m1_err, m1_ack, m0_err, m0_ack}), 32'd0);
                end else begin
                    e  = exp_q.pop_front();
                    ev = e.m ? 2'b10 : 2'b01;
                    chk("ack_master", 32'({m1_ack, m0_ack}), 32'(ev));
                    chk("ack_err", 32'({m1_err, m0_err}), e.err ? 32'(ev) : 32'd0);
                    chk("ack_rd_data", 32'(e.m ? m1_rd_data : m0_rd_data), 32'(e.dat));
                    chk("ack_grant", 32'(grant), 32'(ev));
                end
            end
        end
    end

    initial begin
        int k;
        reset_n = 1'b0;
        m0_addr = '0; m0_rd_req = 0; m0_wr_req = 0; m0_wr_data = '0; m0_lock = 0;
        m1_addr = '0; m1_rd_req = 0; m1_wr_req = 0; m1_wr_data = '0; m1_lock = 0;
        #2;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_strobes", 32'({mem_rd_req, mem_wr_enable}), 32'd0);
        chk("rst_mem_bus", 32'({mem_addr, mem_wr_data}), 32'd0);
        chk("rst_rd_data", 32'({m1_rd_data, m0_rd_data}), 32'd0);
        chk("rst_ack_err", 32'({m1_err, m1_ack, m0_err, m0_ack}), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Tie from reset goes to m0; m0 re-requests at once, so the next tie goes to m1.
        push(0, 8'h10, 0); push(1, 8'h20, 0); push(0, 8'h11, 0);
        req(0, 0, 16'h1000, 8'h00, 0);
        req(1, 0, 16'h2000, 8'h00, 0);
        @(negedge clk);
        chk("tie_grant", 32'(grant), 32'd1);
        chk("tie_addr", 32'(mem_addr), 32'h1000);
        wait_ack(0, k);
        req(0, 0, 16'h1001, 8'h00, 0);
        wait_ack(1, k); drop(1);
        wait_ack(0, k); drop(0);
        @(negedge clk);

        // Single read, ack in the second WAIT cycle.
        push(0, 8'hA9, 0);
        req(0, 0, 16'h0444, 8'h00, 0);
        @(negedge clk);
        chk("rd_grant", 32'(grant), 32'd1);
        chk("rd_strobe", 32'({mem_rd_req, mem_wr_enable}), 32'd2);
        chk("rd_addr", 32'(mem_addr), 32'h0444);
        wait_ack(0, k);
        chk("rd_latency", 32'(k), 32'd2);
        chk("rd_strobe_len", 32'(last_len), 32'd2);
        chk("rd_done_grant", 32'(grant), 32'd1);
        drop(0);
        @(negedge clk);
        chk("idle_grant", 32'(grant), 32'd0);

        // Lock: m0 keeps the bus for two reads although m1 waits and would win the tie.
        push(0, 8'h45, 0); push(0, 8'h46, 0); push(1, 8'h30, 0);
        req(0, 0, 16'h0445, 8'h00, 1);
        @(negedge clk);
        req(1, 0, 16'h3000, 8'h00, 0);
        wait_ack(0, k);
        req(0, 0, 16'h0446, 8'h00, 1);
        @(negedge clk);
        m0_lock = 1'b0;
        wait_ack(0, k); drop(0);
        wait_ack(1, k); drop(1);
        @(negedge clk);

        // Write from m1; its read data must keep the last read value.
        push(1, 8'h30, 0);
        req(1, 1, 16'hD000, 8'h55, 0);
        @(negedge clk);
        chk("wr_strobe", 32'({mem_rd_req, mem_wr_enable}), 32'd1);
        chk("wr_addr", 32'(mem_addr), 32'hD000);
        chk("wr_data", 32'(mem_wr_data), 32'h55);
        chk("wr_grant", 32'(grant), 32'd2);
        wait_ack(1, k); drop(1);
        chk("wr_cap", 32'({cap_wr, cap_wdata}), 32'h155);
        chk("wr_strobe_len", 32'(last_len), 32'd2);
        @(negedge clk);

        // Watchdog: no ack, strobe lasts exactly TIMEOUT cycles.
        ack_delay = 0;
        push(0, 8'hFF, 1);
        req(0, 0, 16'h0500, 8'h00, 0);
        wait_ack(0, k); drop(0);
        chk("to_strobe_len", 32'(last_len), 32'd4);
        @(negedge clk);
        ack_delay = 1;
        push(0, 8'hA9, 0);
        req(0, 0, 16'h0444, 8'h00, 0);
        wait_ack(0, k); drop(0);
        chk("post_to_len", 32'(last_len), 32'd1);
        @(negedge clk);
        // Ack in the same cycle the watchdog would fire: the ack wins.
        ack_delay = 4;
        push(1, 8'h20, 0);
        req(1, 0, 16'h2000, 8'h00, 0);
        wait_ack(1, k); drop(1);
        chk("edge_to_len", 32'(last_len), 32'd4);
        @(negedge clk);

        // Reset in the middle of WAIT drops the strobe without a clock edge.
        ack_delay = 0;
        req(0, 0, 16'h0600, 8'h00, 0);
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_strobe_before", 32'(mem_rd_req), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_strobe_after", 32'(mem_rd_req), 32'd0);
        chk("mid_rst_grant", 32'(grant), 32'd0);
        drop(0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        ack_delay = 2;
        push(0, 8'h10, 0); push(1, 8'h20, 0);
        req(0, 0, 16'h1000, 8'h00, 0);
        req(1, 0, 16'h2000, 8'h00, 0);
        wait_ack(0, k); drop(0);
        wait_ack(1, k); drop(1);

        repeat (5) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter for the shared 8-bit system memory bus. The CPU (master 0) and a second bus master such as a DMA or video fetch unit (master 1) each present single-byte read or write requests, and the arbiter serialises them onto one memory port using the rd_req/rd_ack style handshake. It uses round-robin priority, with a lock option for multi-byte sequences (e.g. 16-bit word fetches) and a watchdog timeout on unresponsive memory.

## Interface
- ADDR_W, 16, address width
- DATA_W, 8, data width
- TIMEOUT, 255, max WAIT cycles before abort; 0 disables the watchdog
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- mX_addr (X=0,1)  in  ADDR_W  request address, stable while mX_rd_req/mX_wr_req high
- mX_rd_req  in  1  read request (level)
- mX_wr_req  in  1  write request (level); wins over mX_rd_req if both high
- mX_wr_data  in  DATA_W  write data
- mX_lock  in  1  keep grant for this master's next request
- mX_rd_data  out  DATA_W  read data, valid while mX_ack high
- mX_ack  out  1  one-cycle completion pulse
- mX_err  out  1  high with mX_ack when the transaction timed out
- mem_addr  out  ADDR_W  memory address
- mem_wr_data  out  DATA_W  memory write data
- mem_wr_enable  out  1  write strobe (level until mem_ack)
- mem_rd_req  out  1  read strobe (level until mem_ack)
- mem_rd_data  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion pulse (reads and writes)
- grant  out  2  one-hot owner of the current transaction; 00 when idle

## Operation
- Reset (async, reset_n=0): state IDLE; all outputs 0 (mem_addr, mem_wr_data, mX_rd_data, grant included); last_grant=1, so master 0 wins the first tie; lock_owner cleared; timeout counter 0.
- FSM: IDLE -> WAIT -> DONE -> IDLE.
- IDLE:
  - A master is requesting if rd_req or wr_req is high.
  - If lock_owner is valid and that master is requesting, grant it.
  - Otherwise, if only one master requests, grant it.
  - If both request, grant the master that is not last_grant.
  - On grant: register mem_addr, mem_wr_data and direction; assert mem_wr_enable (write) or mem_rd_req (read); set grant; update last_grant; clear the counter; go to WAIT.
  - If lock_owner is valid but not requesting, clear lock_owner and arbitrate normally in the same cycle.
- WAIT: hold the strobe and the address.
  - On mem_ack: drop the strobe, capture mem_rd_data into the granted master's mX_rd_data (reads only; holds its last value on writes), pulse that master's mX_ack, and go to DONE.
  - Else, if TIMEOUT≠0 and the counter reaches TIMEOUT-1: drop the strobe, set mX_rd_data=all ones, pulse mX_ack and mX_err, and go to DONE.
  - Otherwise increment the counter.
- DONE: mX_ack (and mX_err, if set) high for exactly this cycle.
  - lock_owner = granted master if its mX_lock is high, else cleared.
  - grant goes to 00 on exit.
  - Requests are ignored this cycle: the master drops its request, or presents a new one, during DONE.
  - Next state is IDLE.
- mem_ack outside WAIT is ignored.
- Requests from the non-granted master are held off; they are never dropped or merged.
- The ungranted master's mX_ack and mX_err stay 0 at all times.

## Timing
- All outputs are registered.
- Read/write latency: request first high in IDLE cycle 0 -> strobe high from cycle 1 -> mem_ack in cycle n (n≥1) -> mX_ack in cycle n+1 -> IDLE in cycle n+2.
- Minimum occupancy is 3 cycles per transaction (mem_ack in the first WAIT cycle).
- Timeout: the strobe stays high for exactly TIMEOUT cycles, and mX_ack/mX_err assert the following cycle.
- mem_ack coinciding with the timeout cycle: the ack wins, with mX_err=0 and real data.
- reset_n low mid-WAIT drops the strobes asynchronously; no mX_ack is generated.
- Both masters requesting in the same IDLE cycle: only one grant, chosen by round-robin (or by lock). The loser is served in the next IDLE, 3+ cycles later.
- Locked master: back-to-back service with no interleaving while mX_lock stays high at each DONE. Other master starvation is bounded only by the lock holder; the lock holder must not hold mX_lock indefinitely.

## Test plan
- Single read: m0 reads 0x0444; memory returns 0xA9 with mem_ack in the 2nd WAIT cycle -> mem_rd_req high for 2 cycles, m0_rd_data=0xA9 with m0_ack in cycle 3, grant=01 during WAIT/DONE.
- Contention: m0 and m1 read 0x1000/0x2000 simultaneously from reset -> m0 is served first, then m1; a repeated simultaneous request now serves m1 first (round-robin).
- Lock: m0 reads 0x0445 with m0_lock=1 and m1 requesting throughout, then reads 0x0446 with m0_lock=0 -> both m0 transactions complete before m1 is granted.
- Write: m1 writes 0x55 to 0xD000 -> mem_wr_enable high with mem_addr=0xD000, mem_wr_data=0x55 until mem_ack; m1_ack pulses once; m1_rd_data unchanged.
- Timeout: TIMEOUT=4, memory never acks -> mem_rd_req high exactly 4 cycles, then m0_ack=1, m0_err=1, m0_rd_data=0xFF; the next request proceeds normally.
- Reset mid-WAIT: assert reset_n=0 during a read -> mem_rd_req falls without a clock edge, no mX_ack; after release, the first tie is granted to m0.
